// File: rtl/updown_pkg.sv
// Shared defaults and direction encoding for the up/down modulo-N counter.
package updown_pkg;
    localparam int DEF_WIDTH    = 4;
    localparam int DEF_MODULUS  = 10;
    localparam int DEF_DIGITS   = 2;
    localparam int DEF_SEC1_MAX = 50_000_000;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;
endpackage

// File: rtl/sec_tick_gen.sv
// Prescaler: free-runs 0..SEC1_MAX-1 while EN, flags the last cycle as TICK.
module sec_tick_gen #(
    parameter int SEC1_MAX = updown_pkg::DEF_SEC1_MAX
) (
    input  logic CLK,
    input  logic RESET,
    input  logic EN,
    input  logic CLR,
    output logic TICK
);
    localparam int CW = (SEC1_MAX > 1) ? $clog2(SEC1_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(SEC1_MAX - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            cnt <= '0;
        else if (CLR)
            cnt <= '0;
        else if (EN)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    assign TICK = EN && (cnt == LAST);
endmodule

// File: rtl/updown_modn.sv
// Cascaded up/down modulo-MODULUS counter stepped by a prescaler tick.
// Optional parallel load enabled by defining UPDOWN_LOAD_EN.
module updown_modn
    import updown_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MODULUS  = DEF_MODULUS,
    parameter int DIGITS   = DEF_DIGITS,
    parameter int SEC1_MAX = DEF_SEC1_MAX
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    EN,
    input  logic                    DEC,
`ifdef UPDOWN_LOAD_EN
    input  logic                    LOAD,
    input  logic [DIGITS*WIDTH-1:0] LOAD_VAL,
`endif
    output logic [DIGITS*WIDTH-1:0] COUNT,
    output logic                    TICK,
    output logic                    CARRY
);
    if (MODULUS < 2 || MODULUS > 2**WIDTH || DIGITS < 1 || SEC1_MAX < 1) begin : g_bad_param
        $fatal(1, "updown_modn: illegal parameters");
    end

    localparam logic [WIDTH-1:0] DMAX = WIDTH'(MODULUS - 1);

    dir_e                    dir;
    logic [DIGITS-1:0]       at_end;
    logic [DIGITS:0]         prop;
    logic [DIGITS*WIDTH-1:0] cnt_nxt;
`ifdef UPDOWN_LOAD_EN
    logic [DIGITS*WIDTH-1:0] ld_clamp;
`endif

    assign dir = dir_e'(DEC);

    sec_tick_gen #(.SEC1_MAX(SEC1_MAX)) u_tick (
        .CLK  (CLK),
        .RESET(RESET),
        .EN   (EN),
`ifdef UPDOWN_LOAD_EN
        .CLR  (LOAD),
`else
        .CLR  (1'b0),
`endif
        .TICK (TICK)
    );

    // Ripple the step through digits sitting at their wrap value.
    always_comb begin
        prop[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            prop[i+1] = prop[i] & at_end[i];
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        logic [WIDTH-1:0] dig;
        logic [WIDTH-1:0] nxt;

        assign dig = COUNT[d*WIDTH +: WIDTH];

        always_comb begin
            if (dir == DOWN) begin
                at_end[d] = (dig == '0);
                nxt       = at_end[d] ? DMAX : dig - 1'b1;
            end else begin
                at_end[d] = (dig == DMAX);
                nxt       = at_end[d] ? '0 : dig + 1'b1;
            end
        end

        assign cnt_nxt[d*WIDTH +: WIDTH] = prop[d] ? nxt : dig;
`ifdef UPDOWN_LOAD_EN
        assign ld_clamp[d*WIDTH +: WIDTH] =
            (LOAD_VAL[d*WIDTH +: WIDTH] > DMAX) ? DMAX : LOAD_VAL[d*WIDTH +: WIDTH];
`endif
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            COUNT <= '0;
            CARRY <= 1'b0;
        end else begin
            CARRY <= 1'b0;
`ifdef UPDOWN_LOAD_EN
            if (LOAD)
                COUNT <= ld_clamp;
            else
`endif
            if (TICK) begin
                COUNT <= cnt_nxt;
                CARRY <= prop[DIGITS];
            end
        end
    end
endmodule
